// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// addresses, TXSTAT bit positions and the shift FSM state encoding.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
package uart_tx_pkg;

  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0040;
  localparam logic [31:0] TXSTAT_ADDR = 32'hFFFF_0044;
  localparam logic [31:0] TXACK_ADDR  = 32'hFFFF_0048;

  localparam int unsigned STAT_EMPTY    = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_BUSY     = 2;
  localparam int unsigned STAT_OVERFLOW = 3;
  localparam int unsigned STAT_IRQ      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // True when the address hits any of the three block registers.
  function automatic logic is_block_addr(input logic [31:0] addr);
    return (addr == TXDATA_ADDR) || (addr == TXSTAT_ADDR) || (addr == TXACK_ADDR);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART shifter. DEPTH must be a power of two so the
// pointers wrap for free. A push while full is only taken when a pop
// happens in the same cycle; a pop while empty is ignored.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt_q;

  // Storage write port.
  // NOTE: the data array has no reset; empty/count guard every read, so
  // clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/TXSTAT/TXACK register decode,
// transmit FIFO, baud counter and the start/data/stop shift FSM.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after data).
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DIV   = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        TxInterrupt,
  output logic [31:0] cycle,
  output logic        TxAddress,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        tx
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  tx_state_e     state_q;
  tx_state_e     state_d;
  logic [15:0]   baud_cnt;
  logic          bit_end;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          line_bit;
  logic          busy;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] unused_fifo_count;
  logic          unused_data;

  logic          wr_txdata;
  logic          wr_txack;
  logic          push_ok;
  logic          ovf_event;
  logic          irq_event;
  logic          irq_pending;
  logic          overflow;
  logic [31:0]   stat_word;

  assign unused_data = ^data[31:8];

  // Register decode: all combinational so the data memory can be gated off
  // in the same cycle.
  assign TxAddress = is_block_addr(address);
  assign wr_txdata = MemWrite && (address == TXDATA_ADDR);
  assign wr_txack  = MemWrite && (address == TXACK_ADDR);

  // A full FIFO still accepts a byte when the shifter pops in the same cycle.
  assign push_ok   = !fifo_full || fifo_pop;
  assign fifo_push = wr_txdata && push_ok;
  assign ovf_event = wr_txdata && !push_ok;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (data[7:0]),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (unused_fifo_count)
  );

  assign bit_end = (state_q != ST_IDLE) && (baud_cnt == 16'(DIV - 1));
  assign busy    = (state_q != ST_IDLE);

  // Shift FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, line level and FIFO pop request.
  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    line_bit  = 1'b1;
    fifo_pop  = 1'b0;
    irq_event = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        line_bit = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        line_bit = shreg[bit_idx];
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        line_bit = ^shreg;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        line_bit = 1'b1;
        if (bit_end) begin
          // Back-to-back frames: the next start bit follows with no idle bit.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_START;
          end else begin
            irq_event = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line is driven straight from the state so reset forces it high at once.
  assign tx = line_bit;

  // Baud counter, data bit index and the byte being shifted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      if (!busy || bit_end) baud_cnt <= '0;
      else                  baud_cnt <= baud_cnt + 16'd1;

      if (fifo_pop) begin
        shreg   <= fifo_rdata;
        bit_idx <= '0;
      end else if ((state_q == ST_DATA) && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Sticky status flags; a set event in the same cycle as TXACK wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (irq_event)     irq_pending <= 1'b1;
      else if (wr_txack) irq_pending <= 1'b0;

      if (ovf_event)     overflow <= 1'b1;
      else if (wr_txack) overflow <= 1'b0;
    end
  end

  assign TxInterrupt = irq_pending;

  // TXSTAT word and load data; only TXSTAT returns non-zero data.
  always_comb begin
    stat_word                = '0;
    stat_word[STAT_EMPTY]    = fifo_empty;
    stat_word[STAT_FULL]     = fifo_full;
    stat_word[STAT_BUSY]     = busy;
    stat_word[STAT_OVERFLOW] = overflow;
    stat_word[STAT_IRQ]      = irq_pending;
  end

  assign cycle = (MemRead && (address == TXSTAT_ADDR)) ? stat_word : 32'd0;

endmodule
